// File: rtl/rxn_pkg.sv
// Shared types and helpers for the multi-player reaction timer.
package rxn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } rxn_state_t;

  // Width of the winner index; a single-player build still gets one bit.
  function automatic int win_w(input int n_players);
    return (n_players > 1) ? $clog2(n_players) : 1;
  endfunction

endpackage

// File: rtl/rxn_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled clocks, phase cleared by clr.
module rxn_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PH_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TICK_DIV - 1);

  logic [PH_W-1:0] phase;

  assign tick = en && (phase == PH_LAST);

  // Phase counter wraps on the tick and only advances while enabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge, whatever the block order.
    if (!rst_n || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= tick ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/rxn_timer_multi.sv
// Multi-player reaction timer: round FSM, time counter, per-player latch bank
// and first-latch winner capture. Every output is a register.
module rxn_timer_multi
  import rxn_pkg::*;
#(
  parameter int N_PLAYERS = 4,
  parameter int CNT_W     = 16,
  parameter int TICK_DIV  = 50000,
  parameter int TIMEOUT   = 2000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arm,
  input  logic                          start,
  input  logic [N_PLAYERS-1:0]          stop,
  output logic                          busy,
  output logic                          rxn_done,
  output logic [N_PLAYERS*CNT_W-1:0]    rxn_time,
  output logic [N_PLAYERS-1:0]          rxn_valid,
  output logic [N_PLAYERS-1:0]          false_start,
  output logic                          timed_out,
  output logic [win_w(N_PLAYERS)-1:0]   winner,
  output logic                          winner_valid
);

  localparam int              WIN_W   = win_w(N_PLAYERS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rxn_state_t           state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic                 tick, tick_clr, tick_en;
  logic [N_PLAYERS-1:0] hit;
  logic                 all_excl, all_done, timeout_hit;
  logic [WIN_W-1:0]     first_hit;

  assign tick_clr = (state == IDLE) && arm;
  assign tick_en  = (state == COUNT);

  rxn_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .en    (tick_en),
    .tick  (tick)
  );

  // Per-player latch qualifiers and the round-exit conditions.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    hit         = '0;
    first_hit   = '0;
    all_excl    = &(false_start | stop);
    timeout_hit = (32'(cnt) == 32'(TIMEOUT));
    if (state == COUNT) hit = stop & ~false_start & ~rxn_valid;
    all_done    = &(false_start | rxn_valid | hit);
    // Scan downward so the lowest latching index wins a tie.
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (hit[i]) first_hit = WIN_W'(i);
    end
  end

  // Next-state logic for the round sequence.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arm) state_nx = ARMED;
      ARMED: begin
        // A false start in the same cycle as start still excludes the player.
        if (all_excl)   state_nx = DONE;
        else if (start) state_nx = COUNT;
      end
      COUNT:   if (all_done || timeout_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register plus the registered status flags derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rxn_done <= 1'b0;
    end else begin
      state    <= state_nx;
      busy     <= (state_nx == ARMED) || (state_nx == COUNT);
      rxn_done <= (state_nx == DONE);
    end
  end

  // Time counter: cleared on arm, advances on prescaler ticks, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick_clr) begin
      cnt <= '0;
    end else if (tick && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Result bank: cleared on arm, false starts in ARMED, latches and winner in COUNT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxn_time     <= '0;
      rxn_valid    <= '0;
      false_start  <= '0;
      timed_out    <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            rxn_time     <= '0;
            rxn_valid    <= '0;
            false_start  <= '0;
            timed_out    <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
          end
        end
        ARMED: false_start <= false_start | stop;
        COUNT: begin
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (hit[i]) rxn_time[i*CNT_W +: CNT_W] <= cnt;
          end
          rxn_valid <= rxn_valid | hit;
          if (|hit && !winner_valid) begin
            winner       <= first_hit;
            winner_valid <= 1'b1;
          end
          // Completion in the timeout cycle takes precedence over the timeout flag.
          if (timeout_hit && !all_done) timed_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rxn_timer_multi.sv
// Self-checking bench: four parameterisations of rxn_timer_multi share one
// stimulus stream; a round-level model predicts results for each of them.
module tb_rxn_timer_multi;

  localparam int NP    = 4;
  localparam int NI    = 4;
  localparam int NEVER = 600;

  // Instance 0: base; 1: short timeout; 2: prescaler 5; 3: 4-bit saturating counter.
  function automatic int inst_w(input int k);
    return (k == 3) ? 4 : 16;
  endfunction
  function automatic int inst_d(input int k);
    return (k == 2) ? 5 : 1;
  endfunction
  function automatic int inst_to(input int k);
    return (k == 1) ? 20 : 100;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, arm, start;
  logic [NP-1:0] stop;

  logic          busy_v  [NI];
  logic          done_v  [NI];
  logic          to_v    [NI];
  logic          wv_v    [NI];
  logic [NP-1:0] valid_v [NI];
  logic [NP-1:0] fs_v    [NI];
  logic [1:0]    win_v   [NI];
  logic [63:0]   time0, time1, time2;
  logic [15:0]   time3;
  logic [15:0]   got_time [NI][NP];

  for (genvar p = 0; p < NP; p++) begin : g_time
    assign got_time[0][p] = time0[p*16 +: 16];
    assign got_time[1][p] = time1[p*16 +: 16];
    assign got_time[2][p] = time2[p*16 +: 16];
    assign got_time[3][p] = {12'd0, time3[p*4 +: 4]};
  end

  rxn_timer_multi #(.N_PLAYERS(4), .CNT_W(16), .TICK_DIV(1), .TIMEOUT(100)) u_base (
    .clk(clk), .rst_n(rst_n), .arm(arm), .start(start), .stop(stop),
    .busy(busy_v[0]), .rxn_done(done_v[0]), .rxn_time(time0), .rxn_valid(valid_v[0]),
    .false_start(fs_v[0]), .timed_out(to_v[0]), .winner(win_v[0]), .winner_valid(wv_v[0]));

  rxn_timer_multi #(.N_PLAYERS(4), .CNT_W(16), .TICK_DIV(1), .TIMEOUT(20)) u_short (
    .clk(clk), .rst_n(rst_n), .arm(arm), .start(start), .stop(stop),
    .busy(busy_v[1]), .rxn_done(done_v[1]), .rxn_time(time1), .rxn_valid(valid_v[1]),
    .false_start(fs_v[1]), .timed_out(to_v[1]), .winner(win_v[1]), .winner_valid(wv_v[1]));

  rxn_timer_multi #(.N_PLAYERS(4), .CNT_W(16), .TICK_DIV(5), .TIMEOUT(100)) u_presc (
    .clk(clk), .rst_n(rst_n), .arm(arm), .start(start), .stop(stop),
    .busy(busy_v[2]), .rxn_done(done_v[2]), .rxn_time(time2), .rxn_valid(valid_v[2]),
    .false_start(fs_v[2]), .timed_out(to_v[2]), .winner(win_v[2]), .winner_valid(wv_v[2]));

  rxn_timer_multi #(.N_PLAYERS(4), .CNT_W(4), .TICK_DIV(1), .TIMEOUT(100)) u_sat (
    .clk(clk), .rst_n(rst_n), .arm(arm), .start(start), .stop(stop),
    .busy(busy_v[3]), .rxn_done(done_v[3]), .rxn_time(time3), .rxn_valid(valid_v[3]),
    .false_start(fs_v[3]), .timed_out(to_v[3]), .winner(win_v[3]), .winner_valid(wv_v[3]));

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Round description: ARMED length, false-start cycle (-1 none), stop offset in COUNT.
  int   r_a;
  int   r_f [NP];
  int   r_t [NP];
  int   n0, nc, min_done, max_done;
  logic all_false;

  // Predictions per instance.
  int            e_time  [NI][NP];
  logic [NP-1:0] e_valid [NI];
  logic [NP-1:0] e_fs    [NI];
  logic          e_to    [NI];
  logic          e_wv    [NI];
  logic [1:0]    e_win   [NI];
  int            e_done  [NI];

  // One clock: outputs are looked at and inputs changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Round-level model: outcome follows from when each player first presses.
  task automatic predict_round();
    int maxf, max_t, c_to, c_end, maxv, d, best;
    all_false = 1'b1;
    maxf      = 0;
    for (int p = 0; p < NP; p++) begin
      if (r_f[p] < 0) all_false = 1'b0;
      else if (r_f[p] > maxf) maxf = r_f[p];
    end
    nc       = n0 + r_a + 2;
    min_done = 1 << 30;
    max_done = 0;
    for (int k = 0; k < NI; k++) begin
      d    = inst_d(k);
      maxv = (1 << inst_w(k)) - 1;
      e_valid[k] = '0;
      e_fs[k]    = '0;
      e_to[k]    = 1'b0;
      e_wv[k]    = 1'b0;
      e_win[k]   = 2'd0;
      for (int p = 0; p < NP; p++) begin
        e_time[k][p] = 0;
        if (r_f[p] >= 0) e_fs[k][p] = 1'b1;
      end
      if (all_false) begin
        e_done[k] = n0 + maxf + 2;
      end else begin
        max_t = 0;
        for (int p = 0; p < NP; p++) if (r_f[p] < 0 && r_t[p] > max_t) max_t = r_t[p];
        // The counter first equals TIMEOUT TIMEOUT*D clocks into COUNT, if it can reach it.
        c_to  = (inst_to(k) <= maxv) ? inst_to(k) * d : (1 << 30);
        c_end = (c_to < max_t) ? c_to : max_t;
        e_to[k] = (c_to < max_t);
        best  = -1;
        for (int p = 0; p < NP; p++) begin
          if (r_f[p] < 0 && r_t[p] <= c_end) begin
            e_valid[k][p] = 1'b1;
            e_time[k][p]  = (r_t[p] / d > maxv) ? maxv : r_t[p] / d;
            if (best < 0 || r_t[p] < r_t[best]) best = p;
          end
        end
        if (best >= 0) begin
          e_wv[k]  = 1'b1;
          e_win[k] = 2'(best);
        end
        e_done[k] = nc + c_end + 1;
      end
      if (e_done[k] < min_done) min_done = e_done[k];
      if (e_done[k] > max_done) max_done = e_done[k];
    end
  endtask

  // Drive one round (with ignored arm/start noise), checking busy/rxn_done every
  // cycle and all results once every instance is back in IDLE.
  task automatic run_round();
    int            k_arm;
    logic [NP-1:0] s;
    n0 = cyc;
    predict_round();
    arm   = 1'b1;
    start = 1'b0;
    stop  = '0;
    step();
    while (cyc <= max_done + 1) begin
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (done_v[k] !== (cyc == e_done[k])) begin
          miscompares++;
          $display("FAIL rxn_done inst%0d cycle %0d: got %0b want %0b", k, cyc - n0, done_v[k], cyc == e_done[k]);
        end
        vectors++;
        if (busy_v[k] !== (cyc < e_done[k])) begin
          miscompares++;
          $display("FAIL busy inst%0d cycle %0d: got %0b want %0b", k, cyc - n0, busy_v[k], cyc < e_done[k]);
        end
        if (cyc == n0 + 1) begin
          vectors++;
          if (valid_v[k] !== '0 || fs_v[k] !== '0 || to_v[k] !== 1'b0 ||
              wv_v[k] !== 1'b0 || win_v[k] !== 2'd0) begin
            miscompares++;
            $display("FAIL arm_clear inst%0d: got valid=%b fs=%b to=%b wv=%b win=%0d want all 0",
                     k, valid_v[k], fs_v[k], to_v[k], wv_v[k], win_v[k]);
          end
          for (int p = 0; p < NP; p++) begin
            vectors++;
            if (got_time[k][p] !== 16'd0) begin
              miscompares++;
              $display("FAIL arm_clear_time inst%0d p%0d: got %0d want 0", k, p, got_time[k][p]);
            end
          end
        end
      end
      k_arm = cyc - n0 - 1;
      arm   = (cyc < min_done) && ($urandom_range(0, 7) == 0);
      start = (k_arm == r_a) ||
              (!all_false && cyc >= nc && cyc < min_done && $urandom_range(0, 7) == 0);
      for (int p = 0; p < NP; p++) begin
        if (cyc >= max_done)                s[p] = 1'b0;
        else if (r_f[p] >= 0)               s[p] = (k_arm == r_f[p]) ? 1'b1 :
                                                   (k_arm >  r_f[p]) ? 1'($urandom_range(0, 1)) : 1'b0;
        else if (!all_false)                s[p] = (cyc == nc + r_t[p]) ? 1'b1 :
                                                   (cyc >  nc + r_t[p]) ? 1'($urandom_range(0, 1)) : 1'b0;
        else                                s[p] = 1'b0;
      end
      stop = s;
      step();
    end
    arm   = 1'b0;
    start = 1'b0;
    stop  = '0;
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < NP; p++) begin
        vectors++;
        if (got_time[k][p] !== 16'(e_time[k][p])) begin
          miscompares++;
          $display("FAIL rxn_time inst%0d p%0d: got %0d want %0d", k, p, got_time[k][p], e_time[k][p]);
        end
      end
      vectors++;
      if (valid_v[k] !== e_valid[k]) begin
        miscompares++;
        $display("FAIL rxn_valid inst%0d: got %b want %b", k, valid_v[k], e_valid[k]);
      end
      vectors++;
      if (fs_v[k] !== e_fs[k]) begin
        miscompares++;
        $display("FAIL false_start inst%0d: got %b want %b", k, fs_v[k], e_fs[k]);
      end
      vectors++;
      if (to_v[k] !== e_to[k]) begin
        miscompares++;
        $display("FAIL timed_out inst%0d: got %b want %b", k, to_v[k], e_to[k]);
      end
      vectors++;
      if (wv_v[k] !== e_wv[k] || win_v[k] !== e_win[k]) begin
        miscompares++;
        $display("FAIL winner inst%0d: got valid=%b idx=%0d want valid=%b idx=%0d",
                 k, wv_v[k], win_v[k], e_wv[k], e_win[k]);
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || valid_v[k] !== '0 || fs_v[k] !== '0 ||
          to_v[k] !== 1'b0 || wv_v[k] !== 1'b0 || win_v[k] !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_flags inst%0d: got busy=%b done=%b valid=%b fs=%b to=%b wv=%b win=%0d want all 0",
                 k, busy_v[k], done_v[k], valid_v[k], fs_v[k], to_v[k], wv_v[k], win_v[k]);
      end
      for (int p = 0; p < NP; p++) begin
        vectors++;
        if (got_time[k][p] !== 16'd0) begin
          miscompares++;
          $display("FAIL reset_time inst%0d p%0d: got %0d want 0", k, p, got_time[k][p]);
        end
      end
    end
  endtask

  task automatic test_basic();
    r_a = 2;
    r_f = '{-1, -1, -1, -1};
    r_t = '{12, 12, 7, 30};
    run_round();
    vectors++;
    if (got_time[0][0] !== 16'd12 || got_time[0][1] !== 16'd12 ||
        got_time[0][2] !== 16'd7  || got_time[0][3] !== 16'd30) begin
      miscompares++;
      $display("FAIL basic_times: got %0d,%0d,%0d,%0d want 12,12,7,30",
               got_time[0][0], got_time[0][1], got_time[0][2], got_time[0][3]);
    end
    vectors++;
    if (valid_v[0] !== 4'b1111 || win_v[0] !== 2'd2 || wv_v[0] !== 1'b1 || to_v[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_status: got valid=%b win=%0d wv=%b to=%b want 1111 2 1 0",
               valid_v[0], win_v[0], wv_v[0], to_v[0]);
    end
  endtask

  task automatic test_false_start();
    r_a = 3;
    r_f = '{-1, 1, -1, -1};
    r_t = '{5, 0, 5, 5};
    run_round();
    vectors++;
    if (fs_v[0] !== 4'b0010 || valid_v[0] !== 4'b1101 || win_v[0] !== 2'd0 || wv_v[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL false_start_status: got fs=%b valid=%b win=%0d wv=%b want 0010 1101 0 1",
               fs_v[0], valid_v[0], win_v[0], wv_v[0]);
    end
  endtask

  task automatic test_tie_timeout();
    r_a = 1;
    r_f = '{-1, -1, -1, -1};
    r_t = '{4, NEVER, NEVER, 4};
    run_round();
    vectors++;
    if (win_v[1] !== 2'd0 || wv_v[1] !== 1'b1 || to_v[1] !== 1'b1 || valid_v[1] !== 4'b1001 ||
        got_time[1][0] !== 16'd4 || got_time[1][3] !== 16'd4) begin
      miscompares++;
      $display("FAIL tie_timeout: got win=%0d wv=%b to=%b valid=%b t0=%0d t3=%0d want 0 1 1 1001 4 4",
               win_v[1], wv_v[1], to_v[1], valid_v[1], got_time[1][0], got_time[1][3]);
    end
  endtask

  task automatic test_prescale_saturate();
    r_a = 0;
    r_f = '{-1, -1, -1, -1};
    r_t = '{23, 40, 50, 23};
    run_round();
    vectors++;
    if (got_time[2][0] !== 16'd4) begin
      miscompares++;
      $display("FAIL prescale_time: got %0d want 4", got_time[2][0]);
    end
    vectors++;
    if (got_time[3][1] !== 16'd15 || got_time[3][2] !== 16'd15 || to_v[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL saturate: got t1=%0d t2=%0d to=%b want 15 15 0", got_time[3][1], got_time[3][2], to_v[3]);
    end
  endtask

  task automatic test_all_false();
    r_a = 3;
    r_f = '{0, 1, 0, 2};
    r_t = '{0, 0, 0, 0};
    run_round();
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (wv_v[k] !== 1'b0 || fs_v[k] !== 4'b1111 || valid_v[k] !== 4'b0000) begin
        miscompares++;
        $display("FAIL all_false inst%0d: got wv=%b fs=%b valid=%b want 0 1111 0000", k, wv_v[k], fs_v[k], valid_v[k]);
      end
    end
  endtask

  task automatic test_reset_mid_round();
    arm = 1'b1;  step();
    arm = 1'b0;  stop = 4'b1000; step();
    stop = '0;   start = 1'b1;   step();
    start = 1'b0; step();
    stop = 4'b0001; step();
    step();
    stop = '0;
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (fs_v[k] !== 4'b1000 || valid_v[k] !== 4'b0001 || busy_v[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL pre_reset inst%0d: got fs=%b valid=%b busy=%b want 1000 0001 1", k, fs_v[k], valid_v[k], busy_v[k]);
      end
    end
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    test_reset();
    arm = 1'b1; step();
    arm = 1'b0; stop = 4'b0010; step();
    stop = '0;  arm = 1'b1;     step();
    arm = 1'b0;
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (fs_v[k] !== 4'b0010 || busy_v[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL arm_while_busy inst%0d: got fs=%b busy=%b want 0010 1", k, fs_v[k], busy_v[k]);
      end
    end
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
  endtask

  task automatic test_random(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      r_a = $urandom_range(0, 4);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 5) == 0) begin
          r_f[p] = $urandom_range(0, r_a);
          r_t[p] = 0;
        end else begin
          r_f[p] = -1;
          r_t[p] = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 40);
        end
      end
      run_round();
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    arm   = 1'b0;
    start = 1'b0;
    stop  = '0;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic();
    test_false_start();
    test_tie_timeout();
    test_prescale_saturate();
    test_all_false();
    test_reset_mid_round();
    test_random(25);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rxn_timer_multi.md
# rxn_timer_multi

Multi-player reaction timer: the parametrised successor of the single-channel reaction timer. It arms a round, counts prescaled time units from a `start` event, and latches a per-player reaction time on each player's first `stop`. It also flags false starts, ends the round on completion or timeout, and reports the winner. It sits between the debounced button/LED front end and the score/display logic of the game.

## Interface
- `N_PLAYERS`, 4, number of player channels (≥1).
- `CNT_W`, 16, width of the time counter and of each reported time.
- `TICK_DIV`, 50000, clocks per time unit (≥1; 1 means count every clock).
- `TIMEOUT`, 2000, round limit in time units (< 2^CNT_W).

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `arm` in 1: begin a new round; honoured in IDLE only.
- `start` in 1: go event (stimulus shown); honoured in ARMED only.
- `stop` in N_PLAYERS: player buttons, level, already synchronised/debounced.
- `busy` out 1: high in ARMED and COUNT.
- `rxn_done` out 1: one-cycle pulse in DONE.
- `rxn_time` out N_PLAYERS*CNT_W: flattened times; player i at bits [i*CNT_W +: CNT_W].
- `rxn_valid` out N_PLAYERS: player's time latched this round.
- `false_start` out N_PLAYERS: player pressed before `start`.
- `timed_out` out 1: round ended by TIMEOUT.
- `winner` out max(1,$clog2(N_PLAYERS)): index of fastest player.
- `winner_valid` out 1: `winner` is meaningful.

## Operation
States: IDLE → ARMED → COUNT → DONE → IDLE.

- **IDLE**
  - On `arm`: clear all result outputs, reset the prescaler and counter to 0, and go to ARMED.
  - Results otherwise hold from the previous round.
- **ARMED**
  - Any `stop[i]` high sets `false_start[i]`. That player is excluded for the rest of the round.
  - `start` with at least one non-excluded player: go to COUNT.
  - All players excluded: go to DONE with `winner_valid`=0.
  - `start` and `stop[i]` in the same cycle: false start wins.
- **COUNT**
  - The prescaler counts 0..TICK_DIV-1. On its wrap, the counter increments, saturating at 2^CNT_W-1.
  - On the first cycle `stop[i]` is high for a non-excluded player with `rxn_valid[i]`=0:
    - `rxn_time[i]` ← current counter value (the pre-increment value if a tick coincides).
    - Set `rxn_valid[i]`.
  - A player already holding `stop` when entering COUNT is already excluded (flagged in ARMED).
  - Winner: the first cycle in which any player latches sets `winner` to the lowest index among the players latching that cycle, and sets `winner_valid`. Later latches never change it.
  - Exit to DONE when every non-excluded player is valid, counting latches made this cycle.
  - Exit to DONE when the counter equals TIMEOUT with players still unresolved; `timed_out` ← 1.
  - If both exit conditions hold in the same cycle, `timed_out` stays 0.
- **DONE**: assert `rxn_done` for one cycle, then go to IDLE.
- `arm` outside IDLE and `start` outside ARMED are ignored.

## Timing
- Reset values: state IDLE, all outputs 0. `rst_n` low mid-round aborts the round in one cycle.
- `arm` sampled at edge k: `busy`=1 from k+1.
- `start` sampled at edge k: COUNT from k+1, counter=0.
- With TICK_DIV=D, the counter reaches value v at D·v clocks after COUNT entry.
- Stop latency: `rxn_time`/`rxn_valid` update at the edge that samples `stop`.
- Round completion: DONE is entered on the next edge, and `rxn_done` is high for exactly that cycle.
- All outputs are registered, with no combinational input-to-output paths.

## Structure
- Package `rxn_pkg` holds:
  - the state enum typedef `rxn_state_t` (IDLE, ARMED, COUNT, DONE);
  - a helper function for the winner index width.
- Sub-module `rxn_tick_gen`:
  - parameter `TICK_DIV`;
  - ports `clk`, `rst_n`, `clr`, `en`, output `tick` (one-cycle pulse every TICK_DIV enabled clocks);
  - `clr` resets its phase to 0.
- Top level contains the FSM, counter, per-player latch bank, and winner capture.

## Test plan
All scenarios use TICK_DIV=1 unless noted.
1. **Basic round.** N=4, TIMEOUT=100. Arm, then start. Stops at counter values 7 (p2), 12 (p0), 12 (p1), 30 (p3).
   - Required: times {12,12,7,30}, `rxn_valid`=4'b1111, `winner`=2, `winner_valid`=1, `timed_out`=0, `rxn_done` one cycle after p3.
2. **False start.** p1 holds `stop` during ARMED; others stop at 5.
   - Required: `false_start`=4'b0010, `rxn_valid[1]`=0, round ends when p0, p2, p3 are valid.
3. **Tie and timeout.** p0 and p3 stop at 4 in the same cycle; p1 and p2 never stop; TIMEOUT=20.
   - Required: `winner`=0, `timed_out`=1, `rxn_done` after the counter hits 20.
4. **Prescaler and saturation.**
   - TICK_DIV=5: a stop 23 clocks after COUNT entry gives time 4.
   - CNT_W=4 with a large TIMEOUT: the counter holds at 15.
5. **All false start.** All players false start.
   - Required: DONE directly from ARMED, `winner_valid`=0, COUNT never entered.
6. **Reset mid-round.** Assert `rst_n`=0 in COUNT.
   - Required: next cycle IDLE, all outputs 0.
   - A subsequent `arm` while `busy` is ignored.
